imem_dmem_arbiter: RTL and testbench
====================================

# imem_dmem_arbiter

Shares one single-ported unified instruction/data memory between the fetch stage and the memory stage of the 5-stage RISC-V pipeline. Data accesses normally have priority. A starvation counter guarantees fetch progress. Fetch responses orphaned by a taken branch or jump are discarded. It drives the fetch and memory stall requests consumed by the hazard unit.

## Interface
- DATA_WIDTH, 32, address/data width
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits (≥1)
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- if_req  input  1  fetch wants the instruction at if_addr; held until if_valid
- if_addr  input  DATA_WIDTH  fetch address (PCF)
- if_kill  input  1  redirect (PCSrcE); current fetch is stale
- if_rdata  output  DATA_WIDTH  instruction
- if_valid  output  1  if_rdata valid this cycle
- dm_req, dm_we  input  1  data access request / write; held until dm_valid
- dm_addr, dm_wdata  input  DATA_WIDTH  data address / write data
- dm_wstrb  input  4  byte enables
- dm_rdata  output  DATA_WIDTH  load data
- dm_valid  output  1  data access complete this cycle
- stall_f, stall_m  output  1  stall requests to hazard unit
- mem_req, mem_we  output  1  memory request / write
- mem_addr, mem_wdata  output  DATA_WIDTH  memory address / write data
- mem_wstrb  output  4  byte enables (4'b0000 on reads)
- mem_gnt  input  1  memory accepts mem_req this cycle
- mem_rvalid  input  1  response/ack for the accepted request
- mem_rdata  input  DATA_WIDTH  read data

## Operation
- FSM states: IDLE, WAIT_I, WAIT_D. One outstanding memory transaction at a time.
- IDLE arbitration:
  - Choose D if dm_req is high and (not if_req, or starve_cnt < STARVE_LIMIT).
  - Otherwise choose I if if_req is high and not if_kill.
  - Drive mem_req and the chosen requester's fields combinationally.
  - On mem_gnt, go to WAIT_I or WAIT_D. Without mem_gnt, stay in IDLE and re-arbitrate next cycle.
- starve_cnt (clog2(STARVE_LIMIT+1) bits, saturating):
  - Increments on each granted data request while if_req is high.
  - Clears on a granted fetch.
  - Clears when if_req is low in IDLE.
- WAIT_D: on mem_rvalid, dm_valid=1 and dm_rdata=mem_rdata (same cycle), then go to IDLE. Writes also complete on mem_rvalid.
- WAIT_I: on mem_rvalid, if_valid=1 and if_rdata=mem_rdata, unless the drop flag is set or if_kill is high. In that case the response is swallowed: if_valid stays 0 and drop clears. Then go to IDLE.
- drop flag: set when if_kill is high in WAIT_I without mem_rvalid. The new PC is fetched after return to IDLE.
- if_kill in IDLE: suppresses a fetch grant that cycle. A data grant is unaffected.
- Stalls:
  - stall_f = if_req & ~if_valid.
  - stall_m = dm_req & ~dm_valid.
- When mem_req is 0, mem_* outputs are 0.

## Timing
- Reset: state=IDLE, starve_cnt=0, drop=0. While rst is high, all outputs are 0, including mem_req.
- Minimum latency is 2 cycles: request granted in cycle N, earliest mem_rvalid and valid output in cycle N+1.
- The requester may change its address in the cycle after valid. The arbiter may grant a new request in that same cycle.
- mem_rvalid is ignored in IDLE (protocol error). The state is unchanged.
- Simultaneous if_req and dm_req in IDLE with starve_cnt=STARVE_LIMIT: fetch wins and starve_cnt clears on its grant.
- rst mid-transaction: return to IDLE immediately. A later mem_rvalid is ignored.
- Back-to-back: valid in cycle N plus re-arbitration in IDLE at N+1 gives at most one access per 2 cycles.

## Test plan
- Fetch only, mem_gnt=1 and mem_rvalid one cycle later; if_addr=0x0,0x4,0x8 returns 0x00500093, … → if_valid every 2nd cycle. stall_f=1 on request cycles and 0 on valid cycles.
- Continuous dm_req loads with if_req held, STARVE_LIMIT=4 → exactly 4 data grants, then 1 fetch grant, repeating. stall_f is high throughout each wait.
- if_kill pulsed in WAIT_I, mem_rvalid 3 cycles later with 0xDEADBEEF → if_valid never asserted for it. The next fetch is granted in the following IDLE cycle.
- Store dm_we=1, dm_addr=0x100, dm_wdata=0x12345678, dm_wstrb=4'b0011 → mem_wstrb=0011 and mem_we=1. dm_valid is asserted on the ack and stall_m drops the same cycle.
- mem_gnt held low 5 cycles with both requests pending → mem_req asserted continuously, state stays IDLE, and data is granted first when gnt rises.
- rst asserted in WAIT_D → next cycle state=IDLE and all outputs 0. A late mem_rvalid produces no dm_valid.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
// Arbiter sharing one single-ported unified memory between instruction fetch and data access.
// Data wins by default; a saturating starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module imem_dmem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [DATA_WIDTH-1:0] if_addr,
    input  logic                  if_kill,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_valid,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [DATA_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    input  logic [3:0]            dm_wstrb,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_valid,
    output logic                  stall_f,
    output logic                  stall_m,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] C_LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_I, S_WAIT_D} state_t;

    state_t        r_state;
    logic [CW-1:0] r_starve;
    logic          r_drop;

    logic w_idle;
    logic w_pick_d;
    logic w_pick_i;
    logic w_we;
    logic w_if_valid;
    logic w_dm_valid;

    // Everything is gated by rst so all outputs read 0 while reset is held.
    assign w_idle     = (r_state == S_IDLE) & ~rst;
    assign w_pick_d   = w_idle & dm_req & (~if_req | (r_starve < C_LIMIT));
    assign w_pick_i   = w_idle & ~w_pick_d & if_req & ~if_kill;
    assign w_we       = w_pick_d & dm_we;
    assign w_if_valid = ~rst & (r_state == S_WAIT_I) & mem_rvalid & ~r_drop & ~if_kill;
    assign w_dm_valid = ~rst & (r_state == S_WAIT_D) & mem_rvalid;

    assign mem_req   = w_pick_d | w_pick_i;
    assign mem_we    = w_we;
    assign mem_addr  = w_pick_d ? dm_addr : (w_pick_i ? if_addr : '0);
    assign mem_wdata = w_pick_d ? dm_wdata : '0;
    assign mem_wstrb = w_we ? dm_wstrb : 4'b0000;

    assign if_valid = w_if_valid;
    assign if_rdata = w_if_valid ? mem_rdata : '0;
    assign dm_valid = w_dm_valid;
    assign dm_rdata = w_dm_valid ? mem_rdata : '0;
    assign stall_f  = ~rst & if_req & ~w_if_valid;
    assign stall_m  = ~rst & dm_req & ~w_dm_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_starve <= '0;
            r_drop   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_drop <= 1'b0;
                    if (w_pick_d && mem_gnt) begin
                        r_state <= S_WAIT_D;
                        if (if_req && (r_starve != C_LIMIT))
                            r_starve <= r_starve + 1'b1;
                    end else if (w_pick_i && mem_gnt) begin
                        r_state  <= S_WAIT_I;
                        r_starve <= '0;
                    end
                    if (!if_req)
                        r_starve <= '0;
                end
                S_WAIT_I: begin
                    // A redirect before the response arrives marks it stale for later.
                    if (mem_rvalid) begin
                        r_state <= S_IDLE;
                        r_drop  <= 1'b0;
                    end else if (if_kill) begin
                        r_drop <= 1'b1;
                    end
                end
                S_WAIT_D: begin
                    if (mem_rvalid)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench: a memory model answers grants, a monitor scoreboards grants and responses.
module tb_imem_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_kill;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        stall_f;
    logic        stall_m;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    imem_dmem_arbiter #(.DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .stall_f(stall_f), .stall_m(stall_m),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_g[$];
    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: fixed contents, accepts whenever gnt_en is set, answers after lat cycles.
    logic gnt_en = 1'b1;
    int   lat    = 1;
    logic pend   = 1'b0;
    int   wcnt   = 0;
    logic p_we   = 1'b0;
    logic [31:0] p_addr = '0;

    assign mem_gnt = gnt_en;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h00: return 32'h00500093;
            32'h04: return 32'h00100113;
            32'h08: return 32'h002081b3;
            32'h0C: return 32'h40208233;
            32'h10: return 32'h00308133;
            32'h14: return 32'hDEADBEEF;
            32'h18: return 32'h0000006f;
            32'h1C: return 32'h00112023;
            default: return {16'hDA7A, a[15:0]};
        endcase
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (mem_req && mem_gnt) begin
                pend   = 1'b1;
                wcnt   = lat - 1;
                p_we   = mem_we;
                p_addr = mem_addr;
            end
        end
    end

    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (pend) begin
                if (wcnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = p_we ? 32'h0 : mem_word(p_addr);
                    pend       = 1'b0;
                end else begin
                    wcnt--;
                end
            end
        end
    end

    // Monitor: every grant and every valid response must match the next expected entry.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_req && mem_gnt) begin
                if (exp_g.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL grant_unexpected: got addr %08h expected none", mem_addr);
                end else begin
                    $display("grant addr=%08h we=%0b", mem_addr, mem_we);
                    chk("grant_addr", mem_addr, exp_g.pop_front());
                end
            end
            if (if_valid) begin
                if (exp_i.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL if_valid_unexpected: got %08h expected none", if_rdata);
                end else begin
                    $display("fetch rsp rdata=%08h", if_rdata);
                    chk("if_rdata", if_rdata, exp_i.pop_front());
                end
            end
            if (dm_valid) begin
                if (exp_d.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL dm_valid_unexpected: got %08h expected none", dm_rdata);
                end else begin
                    $display("data rsp rdata=%08h", dm_rdata);
                    chk("dm_rdata", dm_rdata, exp_d.pop_front());
                end
            end
        end
    end

    logic [31:0] fa [3];
    logic [31:0] fi [3];
    logic [31:0] a;
    int di;

    initial begin
        fa = '{32'h0, 32'h4, 32'h8};
        fi = '{32'h00500093, 32'h00100113, 32'h002081b3};

        // Reset with both requesters active: everything must read 0.
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h4; if_kill = 1'b0;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h300; dm_wdata = 32'hFFFF0000; dm_wstrb = 4'hF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_mem_req", 32'(mem_req), 32'd0);
            chk("rst_mem_addr", mem_addr, 32'd0);
            chk("rst_stall_f", 32'(stall_f), 32'd0);
            chk("rst_stall_m", 32'(stall_m), 32'd0);
            chk("rst_mem_we", 32'(mem_we), 32'd0);
            tick();
        end
        rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; dm_wstrb = 4'h0; dm_wdata = '0;
        tick();

        // Fetch only: valid every second cycle.
        for (int k = 0; k < 3; k++) begin
            if_req = 1'b1; if_addr = fa[k];
            exp_g.push_back(fa[k]); exp_i.push_back(fi[k]);
            @(negedge clk);
            chk("f_req_stall_f", 32'(stall_f), 32'd1);
            chk("f_req_mem_req", 32'(mem_req), 32'd1);
            chk("f_req_if_valid", 32'(if_valid), 32'd0);
            tick();
            @(negedge clk);
            chk("f_val_if_valid", 32'(if_valid), 32'd1);
            chk("f_val_stall_f", 32'(stall_f), 32'd0);
            tick();
        end

        // Starvation: four data grants, then one fetch grant, twice.
        di = 0;
        for (int r = 0; r < 2; r++) begin
            if_req = 1'b1; if_addr = (r == 0) ? 32'h0C : 32'h10;
            for (int k = 0; k < 4; k++) begin
                a = 32'h200 + 32'(4 * di);
                dm_req = 1'b1; dm_we = 1'b0; dm_addr = a;
                exp_g.push_back(a); exp_d.push_back({16'hDA7A, a[15:0]});
                @(negedge clk);
                chk("s_d_mem_addr", mem_addr, a);
                chk("s_d_mem_wstrb", 32'(mem_wstrb), 32'd0);
                chk("s_d_stall_f", 32'(stall_f), 32'd1);
                tick();
                @(negedge clk);
                chk("s_d_dm_valid", 32'(dm_valid), 32'd1);
                chk("s_d_stall_m", 32'(stall_m), 32'd0);
                chk("s_d_wait_stall_f", 32'(stall_f), 32'd1);
                tick();
                di++;
            end
            a = 32'h200 + 32'(4 * di);
            dm_addr = a;
            exp_g.push_back(if_addr);
            exp_i.push_back((r == 0) ? 32'h40208233 : 32'h00308133);
            @(negedge clk);
            chk("s_i_mem_addr", mem_addr, (r == 0) ? 32'h0C : 32'h10);
            chk("s_i_stall_m", 32'(stall_m), 32'd1);
            tick();
            @(negedge clk);
            chk("s_i_if_valid", 32'(if_valid), 32'd1);
            chk("s_i_stall_f", 32'(stall_f), 32'd0);
            tick();
        end
        if_req = 1'b0;
        exp_g.push_back(32'h220); exp_d.push_back(32'hDA7A0220);
        tick();
        tick();
        dm_req = 1'b0;

        // if_kill in IDLE blocks the grant; kill during WAIT_I swallows the late response.
        if_req = 1'b1; if_addr = 32'h14; if_kill = 1'b1;
        @(negedge clk);
        chk("k_idle_mem_req", 32'(mem_req), 32'd0);
        chk("k_idle_stall_f", 32'(stall_f), 32'd1);
        tick();
        if_kill = 1'b0; lat = 3;
        exp_g.push_back(32'h14);
        @(negedge clk);
        chk("k_grant_mem_req", 32'(mem_req), 32'd1);
        tick();
        if_kill = 1'b1;
        @(negedge clk);
        chk("k_w1_if_valid", 32'(if_valid), 32'd0);
        tick();
        if_kill = 1'b0; if_addr = 32'h18;
        @(negedge clk);
        chk("k_w2_mem_req", 32'(mem_req), 32'd0);
        tick();
        lat = 1;
        @(negedge clk);
        chk("k_stale_if_valid", 32'(if_valid), 32'd0);
        chk("k_stale_stall_f", 32'(stall_f), 32'd1);
        tick();
        exp_g.push_back(32'h18); exp_i.push_back(32'h0000006f);
        @(negedge clk);
        chk("k_refetch_mem_req", 32'(mem_req), 32'd1);
        chk("k_refetch_addr", mem_addr, 32'h18);
        tick();
        @(negedge clk);
        chk("k_refetch_if_valid", 32'(if_valid), 32'd1);
        tick();
        if_req = 1'b0;

        // Store with partial strobes.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'h12345678; dm_wstrb = 4'b0011;
        exp_g.push_back(32'h100); exp_d.push_back(32'h0);
        @(negedge clk);
        chk("st_mem_we", 32'(mem_we), 32'd1);
        chk("st_mem_wstrb", 32'(mem_wstrb), 32'h3);
        chk("st_mem_wdata", mem_wdata, 32'h12345678);
        chk("st_stall_m", 32'(stall_m), 32'd1);
        tick();
        @(negedge clk);
        chk("st_dm_valid", 32'(dm_valid), 32'd1);
        chk("st_ack_stall_m", 32'(stall_m), 32'd0);
        tick();
        dm_req = 1'b0;
        @(negedge clk);
        chk("idle_mem_wdata", mem_wdata, 32'd0);
        chk("idle_mem_addr", mem_addr, 32'd0);
        chk("idle_mem_wstrb", 32'(mem_wstrb), 32'd0);
        tick();
        dm_we = 1'b0; dm_wstrb = 4'h0; dm_wdata = '0;

        // Grant withheld for five cycles with both requests pending; data goes first.
        gnt_en = 1'b0;
        if_req = 1'b1; if_addr = 32'h1C; dm_req = 1'b1; dm_addr = 32'h240;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("g_hold_mem_req", 32'(mem_req), 32'd1);
            chk("g_hold_mem_addr", mem_addr, 32'h240);
            tick();
        end
        gnt_en = 1'b1;
        exp_g.push_back(32'h240); exp_d.push_back(32'hDA7A0240);
        tick();
        @(negedge clk);
        chk("g_dm_valid", 32'(dm_valid), 32'd1);
        tick();
        dm_req = 1'b0;
        exp_g.push_back(32'h1C); exp_i.push_back(32'h00112023);
        tick();
        @(negedge clk);
        chk("g_if_valid", 32'(if_valid), 32'd1);
        tick();
        if_req = 1'b0;

        // Reset in WAIT_D; the late response must be ignored.
        lat = 3;
        dm_req = 1'b1; dm_addr = 32'h244;
        exp_g.push_back(32'h244);
        tick();
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h0;
        @(negedge clk);
        chk("r_mem_req", 32'(mem_req), 32'd0);
        chk("r_stall_m", 32'(stall_m), 32'd0);
        chk("r_stall_f", 32'(stall_f), 32'd0);
        chk("r_dm_valid", 32'(dm_valid), 32'd0);
        tick();
        rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk);
        chk("r_after_mem_req", 32'(mem_req), 32'd0);
        tick();
        lat = 1;
        @(negedge clk);
        chk("r_late_dm_valid", 32'(dm_valid), 32'd0);
        tick();
        dm_req = 1'b1; dm_addr = 32'h248;
        exp_g.push_back(32'h248); exp_d.push_back(32'hDA7A0248);
        @(negedge clk);
        chk("r_idle_mem_req", 32'(mem_req), 32'd1);
        tick();
        @(negedge clk);
        chk("r_new_dm_valid", 32'(dm_valid), 32'd1);
        tick();
        dm_req = 1'b0;

        tick();
        tick();
        chk("left_grants", 32'(exp_g.size()), 32'd0);
        chk("left_fetch", 32'(exp_i.size()), 32'd0);
        chk("left_data", 32'(exp_d.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
